hydra_switch: RTL and testbench
===============================

# hydra_switch

Four-port, 16-bit packet switch with one packet-buffer FIFO per input port. Each output port forwards one stored packet per downstream `ready` pulse. The output schedulers pick among input heads by strict priority or round-robin. The block sits between four ingress streaming sources and four egress consumers, and reports buffer pressure through `pause`, `almost_full` and `full`.

## Interface
Parameters:
- `DEPTH`, 1024: words per input FIFO (power of two).
- `W`, 16: data width.

Ports:
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst_n` in 1: synchronous, active-high reset. Despite the name, 1 = reset.
- `wr_sop` in 4: per-input 1-cycle start pulse, one cycle before the first `wr_vld`.
- `wr_eop` in 4: per-input 1-cycle end pulse, one cycle after the last `wr_vld`.
- `wr_vld` in 4: per-input word strobe.
- `wr_data` in 4x16: per-input word.
- `wrr_enable` in 1: 1 = round-robin scheduling; 0 = strict priority.
- `match_threshold` in 5: pressure threshold T, in units of 32 words.
- `match_mode` in 2: pause policy.
- `pause` out 4: per-input backpressure request.
- `full` out 1: some input FIFO has 0 free words.
- `almost_full` out 1: some input FIFO has free < T*32.
- `ready` in 4: per-output 1-cycle pulse, grants one packet.
- `rd_sop`, `rd_eop`, `rd_vld` out 4 each: egress framing, same format as ingress.
- `rd_data` out 4x16: egress word.

## Operation
- **Packet format**
  - First valid word after `wr_sop` is the header: [15:7] = N data words following, [6:4] = priority (7 highest), [3:0] = destination port.
  - The packet is N+1 words.
- **Ingress, per port**
  - State IDLE → HDR on `wr_sop`.
  - HDR: check the first `wr_vld` word. If dest ≥ 4 or free < N+1, go to DROP; otherwise write the header and go to BODY.
  - BODY/DROP: → IDLE on `wr_eop`.
  - BODY writes each `wr_vld` word. DROP discards.
  - On `wr_eop` in BODY, increment that input's complete-packet count.
  - `wr_vld` in IDLE is ignored.
- **Credits:** each output keeps a 4-bit credit counter.
  - `ready[o]` adds 1, saturating at 15.
  - Starting a packet on output o subtracts 1.
- **Eligibility:** input i is eligible for output o when it has ≥1 complete packet, its head header dest = o, and input i is not already being read.
- **Scheduling, per output when idle and credit > 0**
  - `wrr_enable`=0: highest priority wins; ties go to the lowest index.
  - `wrr_enable`=1: round-robin starting after the last granted input, priority ignored.
- **Egress, per output:** states IDLE → SOP → DATA → EOP → IDLE.
  - SOP: `rd_sop` pulses.
  - DATA: N+1 consecutive `rd_vld` words, header first, unchanged.
  - EOP: `rd_eop` pulses, the complete-packet count decrements, and the grant is released.
- **Pressure**
  - Per-port pressure p_i = free_i < T*32.
  - `match_mode` 0: `pause` = 0.
  - `match_mode` 1 or 3: all `pause` bits = OR of p.
  - `match_mode` 2: `pause[i]` = p_i.
  - The DUT still accepts data while `pause` is high.
- **Free accounting:** free_i includes words of dropped packets, which are never written.

## Timing
- **Reset:** all outputs 0. FIFOs empty, credits 0, round-robin pointers at input 0, all FSMs IDLE.
- **Output register:** `rd_*`, `pause`, `full` and `almost_full` are registered.
- **Latency:** when an eligible head and credit are both present at cycle C, the grant is made at C. `rd_sop` is at C+1 and the first `rd_vld` at C+2.
- **Complete packets:** a packet whose `wr_eop` arrives at cycle E is eligible at E+1.
- **Egress stream:** `rd_vld` is gap-free, and `rd_eop` follows the last word by exactly one cycle.
- **Next packet:** the next `rd_sop` on the same output comes no earlier than the cycle after `rd_eop`.
- **Same-cycle events:** a `ready` pulse coinciding with a packet start nets credit unchanged. Simultaneous FIFO write and read on one input are both allowed.
- **Reset mid-packet:** in-flight packets are discarded and nothing is emitted.

## Test plan
- Reset 4 cycles → all outputs 0.
  - Then `ready`=4'hF with empty FIFOs → no `rd_sop`.
- Each input i sends header {N=31, prio 0, dest i} plus 31 data words 1..31, then `ready`=4'hF.
  - Required: each output emits `rd_sop`, then 32 words (header 0x0F80|i, then 1..31), then `rd_eop`.
  - `rd_sop` comes 2 cycles after the later of `ready` and packet completion.
- Inputs 0 and 2 both target output 1, with priorities 2 and 5, `wrr_enable`=0, two `ready[1]` pulses.
  - Required: input 2's packet first, then input 0's.
- Same setup with `wrr_enable`=1 and equal priority over 4 packets.
  - Required: grants alternate 0, 2, 0, 2.
- T=30, `match_mode`=2, fill input 0 with packets until free < 960.
  - Required: `pause`=4'b0001 and `almost_full`=1.
  - With `match_mode`=1: `pause`=4'hF.
  - Fill completely: `full`=1, and the next packet is dropped (no egress).
- Header with dest=5 → packet dropped; free count unchanged.

Source files
------------

// File: rtl/hydra_switch.sv
// Four-port 16-bit packet switch: one packet FIFO per input, credit-gated egress
// per output, strict-priority or round-robin selection among input head packets.
module hydra_switch #(
  parameter int DEPTH = 1024,
  parameter int W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        wr_sop,
  input  logic [3:0]        wr_eop,
  input  logic [3:0]        wr_vld,
  input  logic [3:0][W-1:0] wr_data,
  input  logic              wrr_enable,
  input  logic [4:0]        match_threshold,
  input  logic [1:0]        match_mode,
  output logic [3:0]        pause,
  output logic              full,
  output logic              almost_full,
  input  logic [3:0]        ready,
  output logic [3:0]        rd_sop,
  output logic [3:0]        rd_eop,
  output logic [3:0]        rd_vld,
  output logic [3:0][W-1:0] rd_data
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IN_IDLE, IN_HDR, IN_BODY, IN_DROP} in_state_t;
  typedef enum logic [1:0] {EG_IDLE, EG_SOP, EG_DATA, EG_EOP} eg_state_t;

  logic [W-1:0] w_head [4];
  logic [3:0]   w_has_pkt;
  logic [3:0]   w_press;
  logic [3:0]   w_fifo_full;
  logic [3:0]   w_pop;
  logic [3:0]   w_busy;
  logic [3:0]   w_pkt_done;

  eg_state_t    r_eg_state [4];
  logic [1:0]   r_gnt [4];
  logic [9:0]   r_cnt [4];
  logic [3:0]   r_credit [4];
  logic [1:0]   r_rr [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_in
    logic [W-1:0]  r_mem [DEPTH];
    logic [W-1:0]  r_head;
    in_state_t     r_state;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_used;
    logic [AW:0]   r_pkts;
    logic [AW:0]   w_free;
    logic [AW:0]   w_need;
    logic [AW-1:0] w_rptr_next;
    logic          w_fits;
    logic          w_wr;
    logic          w_eop_body;

    assign w_free      = (AW+1)'(DEPTH) - r_used;
    assign w_need      = (AW+1)'(wr_data[gi][15:7]) + (AW+1)'(1);
    assign w_fits      = (wr_data[gi][3:2] == 2'b00) && (w_need <= w_free);
    assign w_wr        = wr_vld[gi] && (((r_state == IN_HDR) && w_fits) ||
                                        ((r_state == IN_BODY) && (w_free != '0)));
    assign w_eop_body  = (r_state == IN_BODY) && wr_eop[gi];
    assign w_rptr_next = r_rptr + AW'(w_pop[gi]);

    // Read address looks ahead by the pop, so r_head always shows the word at
    // the read pointer: the head header when idle, the next word while streaming.
    always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= wr_data[gi];
      r_head <= r_mem[w_rptr_next];
    end

    always_ff @(posedge clk) begin
      if (rst_n) begin
        r_state <= IN_IDLE;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_used  <= '0;
        r_pkts  <= '0;
      end else begin
        if (w_wr) r_wptr <= r_wptr + 1'b1;
        r_rptr <= w_rptr_next;
        r_used <= r_used + (AW+1)'(w_wr) - (AW+1)'(w_pop[gi]);
        r_pkts <= r_pkts + (AW+1)'(w_eop_body) - (AW+1)'(w_pkt_done[gi]);
        case (r_state)
          IN_IDLE: if (wr_sop[gi]) r_state <= IN_HDR;
          IN_HDR: begin
            if (wr_vld[gi])      r_state <= w_fits ? IN_BODY : IN_DROP;
            else if (wr_eop[gi]) r_state <= IN_IDLE;
          end
          IN_BODY, IN_DROP: if (wr_eop[gi]) r_state <= IN_IDLE;
          default: r_state <= IN_IDLE;
        endcase
      end
    end

    assign w_head[gi]      = r_head;
    assign w_has_pkt[gi]   = (r_pkts != '0);
    assign w_press[gi]     = w_free < (AW+1)'({match_threshold, 5'b0});
    assign w_fifo_full[gi] = (w_free == '0);
  end

  always_comb begin
    w_pop      = '0;
    w_busy     = '0;
    w_pkt_done = '0;
    for (int o = 0; o < 4; o++) begin
      if (r_eg_state[o] != EG_IDLE) w_busy[r_gnt[o]] = 1'b1;
      if ((r_eg_state[o] == EG_SOP) || (r_eg_state[o] == EG_DATA)) w_pop[r_gnt[o]] = 1'b1;
      if (r_eg_state[o] == EG_EOP) w_pkt_done[r_gnt[o]] = 1'b1;
    end
  end

  logic [3:0] w_elig [4];
  logic [1:0] w_pick [4];
  logic [3:0] w_hit;
  logic [3:0] w_start;
  logic [2:0] w_best_pri;
  logic [1:0] w_cand;

  always_comb begin
    w_hit      = '0;
    w_start    = '0;
    w_best_pri = '0;
    w_cand     = '0;
    for (int o = 0; o < 4; o++) begin
      w_elig[o]  = '0;
      w_pick[o]  = '0;
      w_best_pri = '0;
      for (int i = 0; i < 4; i++)
        w_elig[o][i] = w_has_pkt[i] && (w_head[i][3:0] == 4'(o)) && !w_busy[i];
      if (!wrr_enable) begin
        // Strict ">" keeps the lower index on equal priority.
        for (int i = 0; i < 4; i++) begin
          if (w_elig[o][i] && (!w_hit[o] || (w_head[i][6:4] > w_best_pri))) begin
            w_hit[o]   = 1'b1;
            w_pick[o]  = 2'(i);
            w_best_pri = w_head[i][6:4];
          end
        end
      end else begin
        for (int k = 0; k < 4; k++) begin
          w_cand = r_rr[o] + 2'(k);
          if (!w_hit[o] && w_elig[o][w_cand]) begin
            w_hit[o]  = 1'b1;
            w_pick[o] = w_cand;
          end
        end
      end
      w_start[o] = (r_eg_state[o] == EG_IDLE) && (r_credit[o] != 4'd0) && w_hit[o];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int o = 0; o < 4; o++) begin
        r_eg_state[o] <= EG_IDLE;
        r_gnt[o]      <= '0;
        r_cnt[o]      <= '0;
        r_credit[o]   <= '0;
        r_rr[o]       <= '0;
      end
      rd_sop      <= '0;
      rd_eop      <= '0;
      rd_vld      <= '0;
      rd_data     <= '0;
      pause       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      for (int o = 0; o < 4; o++) begin
        rd_sop[o]  <= 1'b0;
        rd_eop[o]  <= 1'b0;
        rd_vld[o]  <= 1'b0;
        rd_data[o] <= '0;
        // A ready pulse in the same cycle as a start leaves the credit as is.
        if (ready[o] && !w_start[o] && (r_credit[o] != 4'd15))
          r_credit[o] <= r_credit[o] + 4'd1;
        else if (!ready[o] && w_start[o])
          r_credit[o] <= r_credit[o] - 4'd1;
        case (r_eg_state[o])
          EG_IDLE: begin
            if (w_start[o]) begin
              r_eg_state[o] <= EG_SOP;
              r_gnt[o]      <= w_pick[o];
              r_rr[o]       <= w_pick[o] + 2'd1;
              r_cnt[o]      <= 10'(w_head[w_pick[o]][15:7]) + 10'd1;
              rd_sop[o]     <= 1'b1;
            end
          end
          EG_SOP, EG_DATA: begin
            rd_vld[o]     <= 1'b1;
            rd_data[o]    <= w_head[r_gnt[o]];
            r_cnt[o]      <= r_cnt[o] - 10'd1;
            r_eg_state[o] <= (r_cnt[o] == 10'd1) ? EG_EOP : EG_DATA;
          end
          EG_EOP: begin
            rd_eop[o]     <= 1'b1;
            r_eg_state[o] <= EG_IDLE;
          end
          default: r_eg_state[o] <= EG_IDLE;
        endcase
      end
      case (match_mode)
        2'd0:    pause <= '0;
        2'd2:    pause <= w_press;
        default: pause <= {4{|w_press}};
      endcase
      almost_full <= |w_press;
      full        <= |w_fifo_full;
    end
  end
endmodule

// File: tb/tb_hydra_switch.sv
// Directed bench for hydra_switch: stimulus pushes expected egress packets into
// per-output queues; a negedge monitor pops and compares what the DUT emits.
module tb_hydra_switch;
  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [3:0]        wr_sop = '0, wr_eop = '0, wr_vld = '0;
  logic [3:0][15:0]  wr_data = '0;
  logic              wrr_enable = 1'b0;
  logic [4:0]        match_threshold = '0;
  logic [1:0]        match_mode = '0;
  logic [3:0]        pause;
  logic              full, almost_full;
  logic [3:0]        ready = '0;
  logic [3:0]        rd_sop, rd_eop, rd_vld;
  logic [3:0][15:0]  rd_data;

  hydra_switch #(.DEPTH(1024), .W(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld),
    .wr_data(wr_data), .wrr_enable(wrr_enable), .match_threshold(match_threshold),
    .match_mode(match_mode), .pause(pause), .full(full), .almost_full(almost_full),
    .ready(ready), .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [15:0] exp_w   [4][$];
  int          exp_len [4][$];
  int          exp_sop [4][$];
  int          sop_cnt [4] = '{default: 0};
  int          eop_cnt [4] = '{default: 0};
  int          word_cnt[4] = '{default: 0};
  bit          last_vld[4] = '{default: 0};
  logic [15:0] mon_w;
  int          mon_len;

  always @(negedge clk) begin
    for (int o = 0; o < 4; o++) begin
      if (rd_sop[o]) begin
        sop_cnt[o]++;
        word_cnt[o] = 0;
        total++;
        if (exp_len[o].size() == 0) begin
          bad++;
          $display("FAIL unexpected_sop out=%0d cyc=%0d", o, cyc);
        end else if (exp_sop[o][0] >= 0 && exp_sop[o][0] != cyc) begin
          bad++;
          $display("FAIL sop_latency out=%0d got_cyc=%0d want_cyc=%0d", o, cyc, exp_sop[o][0]);
        end
      end
      if (rd_vld[o]) begin
        total++;
        word_cnt[o]++;
        if (exp_w[o].size() == 0) begin
          bad++;
          $display("FAIL unexpected_word out=%0d got=%h", o, rd_data[o]);
        end else begin
          mon_w = exp_w[o].pop_front();
          if (rd_data[o] !== mon_w) begin
            bad++;
            $display("FAIL word out=%0d idx=%0d got=%h want=%h", o, word_cnt[o] - 1, rd_data[o], mon_w);
          end
        end
      end
      if (rd_eop[o]) begin
        eop_cnt[o]++;
        total++;
        if (exp_len[o].size() == 0) begin
          bad++;
          $display("FAIL unexpected_eop out=%0d cyc=%0d", o, cyc);
        end else begin
          mon_len = exp_len[o].pop_front();
          void'(exp_sop[o].pop_front());
          if (!last_vld[o] || word_cnt[o] != mon_len) begin
            bad++;
            $display("FAIL eop_framing out=%0d words=%0d want=%0d last_vld=%0d", o, word_cnt[o], mon_len, last_vld[o]);
          end else begin
            $display("pkt out=%0d words=%0d cyc=%0d", o, word_cnt[o], cyc);
          end
        end
      end
      last_vld[o] = rd_vld[o];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
  endtask

  function automatic logic [15:0] base_of(input int i, input int p);
    return 16'((i << 13) | (p << 8));
  endfunction

  task automatic send_pkt(input int i, input logic [15:0] hdr, input logic [15:0] base);
    int n;
    n = int'(hdr[15:7]);
    wr_sop[i] = 1'b1;
    tick();
    wr_sop[i] = 1'b0;
    wr_vld[i] = 1'b1;
    wr_data[i] = hdr;
    tick();
    for (int k = 1; k <= n; k++) begin
      wr_data[i] = base + 16'(k);
      tick();
    end
    wr_vld[i] = 1'b0;
    wr_data[i] = '0;
    wr_eop[i] = 1'b1;
    tick();
    wr_eop[i] = 1'b0;
  endtask

  task automatic expect_pkt(input int o, input logic [15:0] hdr, input logic [15:0] base, input int sop_at);
    int n;
    n = int'(hdr[15:7]);
    exp_w[o].push_back(hdr);
    for (int k = 1; k <= n; k++) exp_w[o].push_back(base + 16'(k));
    exp_len[o].push_back(n + 1);
    exp_sop[o].push_back(sop_at);
  endtask

  task automatic wait_eops(input int o, input int target, input int budget);
    int t;
    t = 0;
    while (eop_cnt[o] < target && t < budget) begin
      tick();
      t++;
    end
    total++;
    if (eop_cnt[o] < target) begin
      bad++;
      $display("FAIL eop_timeout out=%0d got=%0d want=%0d", o, eop_cnt[o], target);
    end
  endtask

  int s, r, tgt;
  int tg[4];

  initial begin
    // Reset state
    do_reset();
    chk("rst_rd_sop", 64'(rd_sop), 0);
    chk("rst_rd_eop", 64'(rd_eop), 0);
    chk("rst_rd_vld", 64'(rd_vld), 0);
    chk("rst_rd_data", 64'(rd_data), 0);
    chk("rst_pause", 64'(pause), 0);
    chk("rst_full", 64'(full), 0);
    chk("rst_almost_full", 64'(almost_full), 0);

    // Credit with empty FIFOs emits nothing
    ready = 4'hF;
    tick();
    ready = 4'h0;
    repeat (10) tick();
    for (int o = 0; o < 4; o++) chk("empty_no_sop", 64'(sop_cnt[o]), 0);

    // Credit already present: rd_sop two cycles after packet completion
    s = cyc;
    for (int i = 0; i < 4; i++) begin
      expect_pkt(i, 16'h0F80 | 16'(i), 16'h0000, s + 35);
      tg[i] = eop_cnt[i] + 1;
    end
    fork
      send_pkt(0, 16'h0F80, 16'h0000);
      send_pkt(1, 16'h0F81, 16'h0000);
      send_pkt(2, 16'h0F82, 16'h0000);
      send_pkt(3, 16'h0F83, 16'h0000);
    join
    for (int o = 0; o < 4; o++) wait_eops(o, tg[o], 100);

    // Packets first, ready later: rd_sop two cycles after ready
    for (int i = 0; i < 4; i++) tg[i] = eop_cnt[i] + 1;
    fork
      send_pkt(0, 16'h0F80, base_of(0, 1));
      send_pkt(1, 16'h0F81, base_of(1, 1));
      send_pkt(2, 16'h0F82, base_of(2, 1));
      send_pkt(3, 16'h0F83, base_of(3, 1));
    join
    repeat (3) tick();
    r = cyc;
    for (int i = 0; i < 4; i++) expect_pkt(i, 16'h0F80 | 16'(i), base_of(i, 1), r + 2);
    ready = 4'hF;
    tick();
    ready = 4'h0;
    for (int o = 0; o < 4; o++) wait_eops(o, tg[o], 100);

    // Strict priority: input 2 (prio 5) before input 0 (prio 2)
    do_reset();
    wrr_enable = 1'b0;
    tgt = eop_cnt[1] + 2;
    fork
      send_pkt(0, 16'h01A1, base_of(0, 0));
      send_pkt(2, 16'h01D1, base_of(2, 0));
    join
    expect_pkt(1, 16'h01D1, base_of(2, 0), -1);
    expect_pkt(1, 16'h01A1, base_of(0, 0), -1);
    ready = 4'b0010;
    tick();
    ready = 4'b0000;
    tick();
    ready = 4'b0010;
    tick();
    ready = 4'b0000;
    wait_eops(1, tgt, 100);

    // Round-robin with equal priority: 0, 2, 0, 2
    do_reset();
    wrr_enable = 1'b1;
    tgt = eop_cnt[1] + 4;
    fork
      begin
        send_pkt(0, 16'h01B1, base_of(0, 0));
        send_pkt(0, 16'h01B1, base_of(0, 1));
      end
      begin
        send_pkt(2, 16'h01B1, base_of(2, 0));
        send_pkt(2, 16'h01B1, base_of(2, 1));
      end
    join
    expect_pkt(1, 16'h01B1, base_of(0, 0), -1);
    expect_pkt(1, 16'h01B1, base_of(2, 0), -1);
    expect_pkt(1, 16'h01B1, base_of(0, 1), -1);
    expect_pkt(1, 16'h01B1, base_of(2, 1), -1);
    for (int k = 0; k < 4; k++) begin
      ready = 4'b0010;
      tick();
    end
    ready = 4'b0000;
    wait_eops(1, tgt, 200);
    wrr_enable = 1'b0;

    // Pressure: T=30 means pressure once free < 960
    do_reset();
    match_threshold = 5'd30;
    match_mode = 2'd2;
    for (int p = 0; p < 2; p++) send_pkt(0, 16'h0F80, base_of(0, p));
    repeat (3) tick();
    chk("pause_free_960", 64'(pause), 0);
    chk("af_free_960", 64'(almost_full), 0);
    send_pkt(0, 16'h0F80, base_of(0, 2));
    repeat (3) tick();
    chk("pause_mode2", 64'(pause), 64'h1);
    chk("af_free_928", 64'(almost_full), 1);
    chk("full_free_928", 64'(full), 0);
    match_mode = 2'd1;
    repeat (2) tick();
    chk("pause_mode1", 64'(pause), 64'hF);
    match_mode = 2'd3;
    repeat (2) tick();
    chk("pause_mode3", 64'(pause), 64'hF);
    match_mode = 2'd0;
    repeat (2) tick();
    chk("pause_mode0", 64'(pause), 0);
    match_mode = 2'd2;
    for (int p = 3; p < 32; p++) send_pkt(0, 16'h0F80, base_of(0, p));
    repeat (3) tick();
    chk("full_when_full", 64'(full), 1);
    send_pkt(0, 16'h0000, 16'h0000);
    repeat (3) tick();
    chk("full_after_drop", 64'(full), 1);
    for (int p = 0; p < 32; p++) expect_pkt(0, 16'h0F80, base_of(0, p), -1);
    tgt = eop_cnt[0];
    for (int p = 0; p < 32; p++) begin
      ready = 4'b0001;
      tick();
      ready = 4'b0000;
      wait_eops(0, tgt + p + 1, 100);
    end
    s = sop_cnt[0];
    ready = 4'b0001;
    tick();
    ready = 4'b0000;
    repeat (40) tick();
    chk("dropped_no_egress", 64'(sop_cnt[0] - s), 0);
    chk("full_drained", 64'(full), 0);
    chk("af_drained", 64'(almost_full), 0);

    // Bad destination is dropped without consuming FIFO space
    do_reset();
    match_threshold = 5'd31;
    match_mode = 2'd2;
    send_pkt(1, 16'h0F83, base_of(1, 0));
    repeat (3) tick();
    chk("pause_free_992", 64'(pause), 0);
    send_pkt(1, 16'h0185, base_of(1, 1));
    repeat (3) tick();
    chk("pause_after_bad_dest", 64'(pause), 0);
    send_pkt(1, 16'h0082, base_of(1, 2));
    repeat (3) tick();
    chk("pause_free_990", 64'(pause), 64'h2);
    expect_pkt(3, 16'h0F83, base_of(1, 0), -1);
    expect_pkt(2, 16'h0082, base_of(1, 2), -1);
    tg[3] = eop_cnt[3] + 1;
    tg[2] = eop_cnt[2] + 1;
    ready = 4'hF;
    tick();
    ready = 4'h0;
    wait_eops(3, tg[3], 100);
    wait_eops(2, tg[2], 100);
    repeat (10) tick();

    for (int o = 0; o < 4; o++) chk("queue_drained", 64'(exp_w[o].size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
